// File: rtl/carfield_domain_seq.sv
`timescale 1ns/1ps
// Carfield power-domain sequencer: walks one island at a time through divider
// programming, clock gating, reset and isolation, picking pending domains round-robin.

module carfield_domain_seq #(
  parameter int unsigned NumDomains   = 6,
  parameter int unsigned DivWidth     = 8,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned IsoCycles    = 2,
  localparam int unsigned IdxW        = (NumDomains > 1) ? $clog2(NumDomains) : 1
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [NumDomains-1:0]          en_i,
  input  logic [NumDomains*DivWidth-1:0] div_value_i,
  output logic                           div_valid_o,
  output logic [IdxW-1:0]                div_idx_o,
  output logic [DivWidth-1:0]            div_value_o,
  input  logic                           div_ready_i,
  output logic [NumDomains-1:0]          clk_en_o,
  output logic [NumDomains-1:0]          rst_no,
  output logic [NumDomains-1:0]          iso_o,
  output logic [NumDomains-1:0]          active_o,
  output logic                           busy_o
);

  localparam int unsigned CntMax = (SettleCycles > IsoCycles) ? SettleCycles : IsoCycles;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax + 1) : 1;
  localparam logic [CntW-1:0] SettleLoad = CntW'(SettleCycles - 1);
  localparam logic [CntW-1:0] IsoLoad    = CntW'(IsoCycles - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_DIV, ST_CLK_SETTLE, ST_RST_ISO, ST_ISO_RST, ST_RST_SETTLE
  } state_e;

  function automatic logic [IdxW-1:0] wrap_idx(input int unsigned base, input int unsigned off);
    int unsigned sum;
    sum = base + off;
    return IdxW'((sum >= NumDomains) ? (sum - NumDomains) : sum);
  endfunction

  // A zero divider would stall the target clock, so it is promoted to 1.
  function automatic logic [DivWidth-1:0] nonzero_div(input logic [DivWidth-1:0] v);
    return (v == '0) ? DivWidth'(1) : v;
  endfunction

  state_e                  state_r, state_s;
  logic [CntW-1:0]         cnt_r, cnt_s;
  logic [IdxW-1:0]         idx_r, idx_s, ptr_r, ptr_s, pick_s;
  logic                    div_valid_r, div_valid_s, busy_r, busy_s, found_s;
  logic [DivWidth-1:0]     div_value_r, div_value_s;
  logic [NumDomains-1:0]   clk_en_r, clk_en_s, dom_rst_n_r, dom_rst_n_s;
  logic [NumDomains-1:0]   iso_r, iso_s, active_r, active_s, pending_s;

  assign pending_s = en_i ^ active_r;

  // Round-robin search for the first pending domain at or after the pointer.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    for (int unsigned i = 0; i < NumDomains; i++) begin
      if (!found_s && pending_s[wrap_idx(32'(ptr_r), i)]) begin
        found_s = 1'b1;
        pick_s  = wrap_idx(32'(ptr_r), i);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state and next-output logic of the sequencer.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    idx_s       = idx_r;
    ptr_s       = ptr_r;
    div_valid_s = div_valid_r;
    div_value_s = div_value_r;
    clk_en_s    = clk_en_r;
    dom_rst_n_s = dom_rst_n_r;
    iso_s       = iso_r;
    active_s    = active_r;
    busy_s      = busy_r;
    case (state_r)
      ST_IDLE: begin
        if (found_s) begin
          idx_s  = pick_s;
          busy_s = 1'b1;
          if (en_i[pick_s]) begin
            state_s     = ST_DIV;
            div_valid_s = 1'b1;
            div_value_s = nonzero_div(div_value_i[pick_s*DivWidth +: DivWidth]);
          end else begin
            state_s       = ST_ISO_RST;
            iso_s[pick_s] = 1'b1;
            cnt_s         = IsoLoad;
          end
        end else begin
          busy_s = 1'b0;
        end
      end
      ST_DIV: begin
        if (div_ready_i) begin
          state_s         = ST_CLK_SETTLE;
          div_valid_s     = 1'b0;
          clk_en_s[idx_r] = 1'b1;
          cnt_s           = SettleLoad;
        end else begin
          div_valid_s = 1'b1;
        end
      end
      ST_CLK_SETTLE: begin
        if (cnt_r == '0) begin
          state_s            = ST_RST_ISO;
          dom_rst_n_s[idx_r] = 1'b1;
          cnt_s              = IsoLoad;
        end else begin
          cnt_s = cnt_r - CntW'(1);
        end
      end
      ST_RST_ISO: begin
        if (cnt_r == '0) begin
          state_s         = ST_IDLE;
          iso_s[idx_r]    = 1'b0;
          active_s[idx_r] = 1'b1;
          busy_s          = 1'b0;
          ptr_s           = wrap_idx(32'(idx_r), 32'd1);
        end else begin
          cnt_s = cnt_r - CntW'(1);
        end
      end
      ST_ISO_RST: begin
        if (cnt_r == '0) begin
          state_s            = ST_RST_SETTLE;
          dom_rst_n_s[idx_r] = 1'b0;
          cnt_s              = SettleLoad;
        end else begin
          cnt_s = cnt_r - CntW'(1);
        end
      end
      ST_RST_SETTLE: begin
        if (cnt_r == '0) begin
          state_s         = ST_IDLE;
          clk_en_s[idx_r] = 1'b0;
          active_s[idx_r] = 1'b0;
          busy_s          = 1'b0;
          ptr_s           = wrap_idx(32'(idx_r), 32'd1);
        end else begin
          cnt_s = cnt_r - CntW'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and all output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      idx_r       <= '0;
      ptr_r       <= '0;
      div_valid_r <= 1'b0;
      div_value_r <= '0;
      clk_en_r    <= '0;
      dom_rst_n_r <= '0;
      iso_r       <= '1;
      active_r    <= '0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      idx_r       <= idx_s;
      ptr_r       <= ptr_s;
      div_valid_r <= div_valid_s;
      div_value_r <= div_value_s;
      clk_en_r    <= clk_en_s;
      dom_rst_n_r <= dom_rst_n_s;
      iso_r       <= iso_s;
      active_r    <= active_s;
      busy_r      <= busy_s;
    end
  end

  assign div_valid_o = div_valid_r;
  assign div_idx_o   = idx_r;
  assign div_value_o = div_value_r;
  assign clk_en_o    = clk_en_r;
  assign rst_no      = dom_rst_n_r;
  assign iso_o       = iso_r;
  assign active_o    = active_r;
  assign busy_o      = busy_r;

  carfield_domain_seq_checker #(
    .NumDomains(NumDomains), .DivWidth(DivWidth), .SettleCycles(SettleCycles),
    .IsoCycles(IsoCycles), .IdxW(IdxW)
  ) u_checker (
    .clk_i(clk_i), .rst_ni(rst_ni), .div_valid_o(div_valid_r), .div_ready_i(div_ready_i),
    .div_idx_o(idx_r), .div_value_o(div_value_r)
  );

endmodule

// Parameter sanity and divider-handshake stability properties for the sequencer.
module carfield_domain_seq_checker #(
  parameter int unsigned NumDomains   = 6,
  parameter int unsigned DivWidth     = 8,
  parameter int unsigned SettleCycles = 4,
  parameter int unsigned IsoCycles    = 2,
  parameter int unsigned IdxW         = 3
) (
  input logic                clk_i,
  input logic                rst_ni,
  input logic                div_valid_o,
  input logic                div_ready_i,
  input logic [IdxW-1:0]     div_idx_o,
  input logic [DivWidth-1:0] div_value_o
);

  if (NumDomains < 1) begin : g_num_domains
    $error("NumDomains must be at least 1");
  end
  if (SettleCycles < 1) begin : g_settle_cycles
    $error("SettleCycles must be at least 1");
  end
  if (IsoCycles < 1) begin : g_iso_cycles
    $error("IsoCycles must be at least 1");
  end

  div_stable_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (div_valid_o && !div_ready_i) |=> ($stable(div_idx_o) && $stable(div_value_o)))
    else $error("divider payload changed while waiting for ready");

endmodule

// File: tb/tb_carfield_domain_seq.sv
`timescale 1ns/1ps
// Scoreboard bench for carfield_domain_seq: a timeline model predicts per-cycle outputs
// and divider transactions; a negedge monitor compares them against the DUT.

module tb_carfield_domain_seq;
  localparam int N = 6, DW = 8, S = 4, I = 2, IW = 3;

  logic clk = 1'b0, rst_ni, div_valid_o, div_ready_i, busy_o;
  logic [N-1:0] en_i, clk_en_o, rst_no, iso_o, active_o;
  logic [N*DW-1:0] div_value_i;
  logic [IW-1:0] div_idx_o;
  logic [DW-1:0] div_value_o;

  carfield_domain_seq #(.NumDomains(N), .DivWidth(DW), .SettleCycles(S), .IsoCycles(I)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .en_i(en_i), .div_value_i(div_value_i),
    .div_valid_o(div_valid_o), .div_idx_o(div_idx_o), .div_value_o(div_value_o),
    .div_ready_i(div_ready_i), .clk_en_o(clk_en_o), .rst_no(rst_no), .iso_o(iso_o),
    .active_o(active_o), .busy_o(busy_o));

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] clk_en, rst_n, iso, act;
    logic dv, busy;
    logic [IW-1:0] didx;
    logic [DW-1:0] dval;
    int cyc;
  } snap_t;
  typedef struct { logic [IW-1:0] idx; logic [DW-1:0] val; } div_exp_t;

  snap_t snap_q[$];
  div_exp_t div_q[$];
  int total = 0, bad = 0;

  // Model: settled per-domain state plus the timeline of the one sequence in flight.
  logic [N-1:0] m_clk, m_rst, m_iso, m_act;
  logic [DW-1:0] m_val;
  int m_ptr, m_idx, m_g, m_h, cyc = 0;
  bit m_seq, m_on;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp, input int c);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, got, exp);
    end
  endtask

  task automatic model_reset();
    m_clk = '0; m_rst = '0; m_iso = '1; m_act = '0;
    m_ptr = 0; m_seq = 1'b0; m_on = 1'b0; m_idx = 0; m_g = 0; m_h = -1; m_val = '0;
  endtask

  function automatic int seq_end();
    if (m_on) return (m_h < 0) ? 32'h7fff_ffff : m_h + 1 + S + I;
    return m_g + 1 + I + S;
  endfunction

  function automatic snap_t model_snap(input int c);
    snap_t s;
    s.clk_en = m_clk; s.rst_n = m_rst; s.iso = m_iso; s.act = m_act;
    s.dv = 1'b0; s.busy = 1'b0; s.didx = IW'(m_idx); s.dval = m_val; s.cyc = c;
    if (m_seq && c >= m_g + 1) begin
      s.busy = 1'b1;
      if (m_on) begin
        s.dv = (m_h < 0) || (c <= m_h);
        if (m_h >= 0 && c >= m_h + 1) s.clk_en[m_idx] = 1'b1;
        if (m_h >= 0 && c >= m_h + 1 + S) s.rst_n[m_idx] = 1'b1;
      end else begin
        s.iso[m_idx] = 1'b1;
        if (c >= m_g + 1 + I) s.rst_n[m_idx] = 1'b0;
      end
    end
    return s;
  endfunction

  // One clock cycle: retire, predict, drive inputs, then let the model react to them.
  task automatic step(input logic [N-1:0] en, input logic [N*DW-1:0] vals, input bit rdy, input bit run);
    logic [DW-1:0] v;
    bit found;
    int d;
    @(posedge clk); #1;
    if (m_seq && cyc == seq_end()) begin
      if (m_on) begin
        m_clk[m_idx] = 1'b1; m_rst[m_idx] = 1'b1; m_iso[m_idx] = 1'b0; m_act[m_idx] = 1'b1;
      end else begin
        m_clk[m_idx] = 1'b0; m_rst[m_idx] = 1'b0; m_iso[m_idx] = 1'b1; m_act[m_idx] = 1'b0;
      end
      m_ptr = (m_idx + 1) % N;
      m_seq = 1'b0;
    end
    snap_q.push_back(model_snap(cyc));
    en_i = en; div_value_i = vals; div_ready_i = rdy;
    if (run) begin
      rst_ni = 1'b1;
      if (!m_seq) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          d = (m_ptr + k) % N;
          if (!found && en[d] != m_act[d]) begin
            found = 1'b1; m_seq = 1'b1; m_idx = d; m_on = en[d]; m_g = cyc; m_h = -1;
            if (m_on) begin
              v = vals[d*DW +: DW];
              m_val = (v == '0) ? DW'(1) : v;
              div_q.push_back('{IW'(d), m_val});
            end
          end
        end
      end else if (m_on && m_h < 0 && cyc >= m_g + 1 && rdy) begin
        m_h = cyc;
      end
    end
    cyc++;
  endtask

  task automatic do_reset(input logic [N-1:0] en, input logic [N*DW-1:0] vals);
    logic [N-1:0] ones;
    ones = '1;
    @(posedge clk); #1;
    rst_ni = 1'b0;
    #1;
    chk("rst_clk_en", 32'(clk_en_o), 32'(0), cyc);
    chk("rst_rst_n", 32'(rst_no), 32'(0), cyc);
    chk("rst_iso", 32'(iso_o), 32'(ones), cyc);
    chk("rst_active", 32'(active_o), 32'(0), cyc);
    chk("rst_div_valid", 32'(div_valid_o), 32'(0), cyc);
    chk("rst_busy", 32'(busy_o), 32'(0), cyc);
    snap_q.delete(); div_q.delete();
    model_reset();
    cyc++;
    repeat (3) step(en, vals, 1'b1, 1'b0);
  endtask

  task automatic wait_active(input int d, input bit lvl, input logic [N-1:0] en,
                             input logic [N*DW-1:0] vals, input int c0, input int exp_lat,
                             input string name);
    int lat;
    lat = -1;
    for (int k = 0; k < 60 && lat < 0; k++) begin
      step(en, vals, 1'b1, 1'b1);
      if (active_o[d] == lvl) lat = cyc - 1 - c0;
    end
    chk(name, 32'(lat), 32'(exp_lat), cyc - 1);
  endtask

  // Monitor: compares every predicted cycle and every divider handshake.
  initial begin
    snap_t e;
    div_exp_t x;
    forever begin
      @(negedge clk);
      if (snap_q.size() > 0) begin
        e = snap_q.pop_front();
        chk("clk_en", 32'(clk_en_o), 32'(e.clk_en), e.cyc);
        chk("rst_n", 32'(rst_no), 32'(e.rst_n), e.cyc);
        chk("iso", 32'(iso_o), 32'(e.iso), e.cyc);
        chk("active", 32'(active_o), 32'(e.act), e.cyc);
        chk("busy", 32'(busy_o), 32'(e.busy), e.cyc);
        chk("div_valid", 32'(div_valid_o), 32'(e.dv), e.cyc);
        if (e.dv) begin
          chk("div_idx", 32'(div_idx_o), 32'(e.didx), e.cyc);
          chk("div_value", 32'(div_value_o), 32'(e.dval), e.cyc);
        end
      end
      if (rst_ni && div_valid_o && div_ready_i) begin
        if (div_q.size() == 0) begin
          chk("div_unexpected", 32'(div_valid_o), 32'(0), cyc);
        end else begin
          x = div_q.pop_front();
          chk("div_txn_idx", 32'(div_idx_o), 32'(x.idx), cyc);
          chk("div_txn_value", 32'(div_value_o), 32'(x.val), cyc);
        end
      end
    end
  end

  initial begin
    logic [N*DW-1:0] vals;
    logic [N-1:0] en;
    int c0;
    rst_ni = 1'b1; en_i = '0; div_value_i = '0; div_ready_i = 1'b1;
    model_reset();
    #1 rst_ni = 1'b0;
    repeat (3) step('0, '0, 1'b1, 1'b0);

    // T1: idle after reset
    repeat (20) step('0, '0, 1'b1, 1'b1);

    // T2: domain 2 on, ready high
    vals = '0; vals[2*DW +: DW] = 8'd4;
    wait_active(2, 1'b1, 6'b000100, vals, cyc, 8, "t2_on_latency");

    // T3: domain 2 off, then on with a stalled divider and zero divider value
    wait_active(2, 1'b0, 6'b000000, vals, cyc, 7, "t3_off_latency");
    vals[2*DW +: DW] = 8'd0;
    c0 = cyc;
    step(6'b000100, vals, 1'b1, 1'b1);
    repeat (5) step(6'b000100, vals, 1'b0, 1'b1);
    wait_active(2, 1'b1, 6'b000100, vals, c0, 13, "t3_stall_latency");

    // T4: three domains at once, then a mixed ON/OFF request
    wait_active(2, 1'b0, 6'b000000, vals, cyc, 7, "t4_prep_off");
    vals = 48'h0605_0403_0201;
    wait_active(2, 1'b1, 6'b000111, vals, cyc, 24, "t4_third_on");
    wait_active(0, 1'b0, 6'b100110, vals, cyc, 15, "t4_rr_order");

    // T5: drop the request mid-ON; the OFF sequence follows
    wait_active(1, 1'b0, 6'b100100, vals, cyc, 7, "t5_prep_off");
    c0 = cyc;
    repeat (4) step(6'b100110, vals, 1'b1, 1'b1);
    wait_active(1, 1'b1, 6'b100100, vals, c0, 8, "t5_on_done");
    wait_active(1, 1'b0, 6'b100100, vals, c0, 15, "t5_off_done");

    // T6: reset in the middle of an ON sequence, then re-sequence from the pointer
    repeat (20) step('0, vals, 1'b1, 1'b1);
    vals[2*DW +: DW] = 8'd4;
    repeat (5) step(6'b000100, vals, 1'b1, 1'b1);
    do_reset(6'b000100, vals);
    wait_active(2, 1'b1, 6'b000100, vals, cyc, 8, "t6_resequence");

    // Random traffic with one reset in the middle
    en = 6'b000100;
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) en[$urandom_range(0, N-1)] ^= 1'b1;
      vals = {$urandom, $urandom};
      if (k == 200) do_reset(en, vals);
      step(en, vals, $urandom_range(0, 3) != 0, 1'b1);
    end
    repeat (60) step(en, vals, 1'b1, 1'b1);
    @(negedge clk); #1;
    chk("div_queue_drained", 32'(div_q.size()), 32'(0), cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
